// File: rtl/axi_lite_rd_bridge.sv
// AXI4-Lite read-channel slave in front of the memory read stage.
// Accepts one AR at a time, validates size/alignment, issues a single-cycle
// mem_ren, waits (with timeout) for the memory reply and returns lane-placed
// data on the R channel.
module axi_lite_rd_bridge #(
   parameter int DELAY   = 0,
   parameter int TIMEOUT = 16
) (
   input  logic        ACLK,
   input  logic        ARESETn,
   input  logic [31:0] s_araddr,
   input  logic [2:0]  s_arsize,
   input  logic        s_arvalid,
   output logic        s_arready,
   output logic [31:0] s_rdata,
   output logic [1:0]  s_rresp,
   output logic        s_rvalid,
   input  logic        s_rready,
   output logic        mem_ren,
   output logic [31:0] mem_raddr,
   output logic [7:0]  mem_wmask,
   input  logic [31:0] mem_rdata,
   input  logic        mem_rvalid
);

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_WAIT      = 3'd1;
   localparam logic [2:0] ST_REQ       = 3'd2;
   localparam logic [2:0] ST_RESP_WAIT = 3'd3;
   localparam logic [2:0] ST_RESP      = 3'd4;

   localparam logic [1:0] RESP_OKAY   = 2'd0;
   localparam logic [1:0] RESP_SLVERR = 2'd2;
   localparam logic [1:0] RESP_DECERR = 2'd3;

   localparam logic [7:0] DELAY_C   = 8'(DELAY);
   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

   logic [2:0] state;
   logic [7:0] cnt;

   // Size must be 1/2/4 bytes and the address naturally aligned to it.
   function automatic logic is_legal(input logic [2:0] size, input logic [1:0] off);
      case (size)
         3'd0:    is_legal = 1'b1;
         3'd1:    is_legal = ~off[0];
         3'd2:    is_legal = (off == 2'b00);
         default: is_legal = 1'b0;
      endcase
   endfunction

   // Mask right-justified memory data to the access length, then move it to
   // its byte lanes. Length comes from the low bits of the latched length code.
   function automatic logic [31:0] place_lanes(input logic [31:0] data,
                                               input logic [1:0]  len,
                                               input logic [1:0]  off);
      logic [31:0] masked;
      if (len[0])
         masked = {24'd0, data[7:0]};
      else if (len[1])
         masked = {16'd0, data[15:0]};
      else
         masked = data;
      place_lanes = masked << {off, 3'b000};
   endfunction

   assign s_arready = (state == ST_IDLE);
   assign s_rvalid  = (state == ST_RESP);
   assign mem_ren   = (state == ST_REQ);

   // Transaction sequencer: accept, optional delay, strobe, wait/timeout, respond.
   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         state     <= ST_IDLE;
         cnt       <= 8'd0;
         s_rdata   <= 32'd0;
         s_rresp   <= RESP_OKAY;
         mem_raddr <= 32'd0;
         mem_wmask <= 8'b100;
      end else begin
         case (state)
            ST_IDLE: begin
               if (s_arvalid) begin
                  if (is_legal(s_arsize, s_araddr[1:0])) begin
                     mem_raddr <= s_araddr;
                     mem_wmask <= 8'd1 << s_arsize;
                     if (DELAY > 0) begin
                        cnt   <= DELAY_C;
                        state <= ST_WAIT;
                     end else begin
                        state <= ST_REQ;
                     end
                  end else begin
                     s_rdata <= 32'd0;
                     s_rresp <= RESP_SLVERR;
                     state   <= ST_RESP;
                  end
               end
            end
            ST_WAIT: begin
               if (cnt == 8'd1)
                  state <= ST_REQ;
               else
                  cnt <= cnt - 8'd1;
            end
            ST_REQ: begin
               cnt   <= 8'd0;
               state <= ST_RESP_WAIT;
            end
            ST_RESP_WAIT: begin
               if (mem_rvalid) begin
                  s_rdata <= place_lanes(mem_rdata, mem_wmask[1:0], mem_raddr[1:0]);
                  s_rresp <= RESP_OKAY;
                  state   <= ST_RESP;
               end else if ((cnt + 8'd1) == TIMEOUT_C) begin
                  s_rdata <= 32'd0;
                  s_rresp <= RESP_DECERR;
                  state   <= ST_RESP;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            ST_RESP: begin
               if (s_rready)
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_lite_rd_bridge.sv
// Bench for axi_lite_rd_bridge: directed test-plan steps followed by random
// reads, each compared against an address/size/data reference model.
module tb_axi_lite_rd_bridge;

   localparam int DELAY   = 0;
   localparam int TIMEOUT = 4;

   logic        ACLK;
   logic        ARESETn;
   logic [31:0] s_araddr;
   logic [2:0]  s_arsize;
   logic        s_arvalid;
   logic        s_arready;
   logic [31:0] s_rdata;
   logic [1:0]  s_rresp;
   logic        s_rvalid;
   logic        s_rready;
   logic        mem_ren;
   logic [31:0] mem_raddr;
   logic [7:0]  mem_wmask;
   logic [31:0] mem_rdata;
   logic        mem_rvalid;

   int checks = 0;
   int errors = 0;

   axi_lite_rd_bridge #(.DELAY(DELAY), .TIMEOUT(TIMEOUT)) dut (
      .ACLK       (ACLK),
      .ARESETn    (ARESETn),
      .s_araddr   (s_araddr),
      .s_arsize   (s_arsize),
      .s_arvalid  (s_arvalid),
      .s_arready  (s_arready),
      .s_rdata    (s_rdata),
      .s_rresp    (s_rresp),
      .s_rvalid   (s_rvalid),
      .s_rready   (s_rready),
      .mem_ren    (mem_ren),
      .mem_raddr  (mem_raddr),
      .mem_wmask  (mem_wmask),
      .mem_rdata  (mem_rdata),
      .mem_rvalid (mem_rvalid)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge ACLK);
      #1;
   endtask

   // One complete read: present AR, act as the memory, check the response,
   // optionally stall R for 'hold' cycles, then complete the R handshake.
   task automatic do_read(input logic [31:0] addr, input logic [2:0] size,
                          input logic [31:0] mdata, input bit silent, input int hold);
      bit          legal;
      int          bytes;
      int          off;
      logic [31:0] edata;
      logic [1:0]  eresp;
      int          elat;
      int          lat;
      int          nren;
      bit          ar_bad;
      bit          hs;
      bit          pend;
      bit          stable_bad;
      logic [31:0] rd0;
      logic [1:0]  rr0;

      // Reference: legal iff size is 1/2/4 bytes and addr is a multiple of it.
      off   = int'(addr[1:0]);
      bytes = 1 << size;
      legal = (size <= 3'd2) && ((off % bytes) == 0);
      if (!legal) begin
         eresp = 2'd2;
         edata = 32'd0;
         elat  = 1;
      end else if (silent) begin
         eresp = 2'd3;
         edata = 32'd0;
         elat  = 2 + TIMEOUT + DELAY;
      end else begin
         eresp = 2'd0;
         elat  = 3 + DELAY;
         edata = (bytes == 4) ? mdata : (mdata % (32'd1 << (8 * bytes)));
         edata = edata * (32'd1 << (8 * off));
      end

      s_araddr  = addr;
      s_arsize  = size;
      s_arvalid = 1'b1;
      hs = 1'b0;
      for (int i = 0; i < 20 && !hs; i++) begin
         if (s_arready) hs = 1'b1;
         step();
      end
      chk("ar_handshake", 32'(hs), 32'd1);
      s_arvalid = 1'b0;
      s_araddr  = $urandom;
      s_arsize  = 3'($urandom);

      lat    = -1;
      nren   = 0;
      ar_bad = 1'b0;
      pend   = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         mem_rvalid = pend;
         mem_rdata  = pend ? mdata : $urandom;
         pend = 1'b0;
         if (mem_ren) begin
            nren++;
            chk("mem_raddr", mem_raddr, addr);
            chk("mem_wmask", 32'(mem_wmask), 32'(8'd1 << size));
            if (!silent) pend = 1'b1;
         end
         if (s_rvalid) begin
            lat = c;
            break;
         end
         if (s_arready) ar_bad = 1'b1;
         step();
      end
      mem_rvalid = 1'b0;

      chk("rvalid_latency", 32'(lat), 32'(elat));
      chk("mem_ren_count", 32'(nren), legal ? 32'd1 : 32'd0);
      chk("arready_low_busy", 32'(ar_bad), 32'd0);
      chk("rdata", s_rdata, edata);
      chk("rresp", 32'(s_rresp), 32'(eresp));

      rd0 = s_rdata;
      rr0 = s_rresp;
      stable_bad = 1'b0;
      for (int h = 0; h < hold; h++) begin
         step();
         if (!s_rvalid || s_rdata !== rd0 || s_rresp !== rr0 || s_arready)
            stable_bad = 1'b1;
      end
      if (hold > 0) chk("hold_stable", 32'(stable_bad), 32'd0);

      s_rready = 1'b1;
      step();
      s_rready = 1'b0;
      chk("arready_after_r", 32'(s_arready), 32'd1);
      chk("rvalid_after_r", 32'(s_rvalid), 32'd0);
   endtask

   initial begin
      logic [31:0] a;
      logic [2:0]  sz;

      ARESETn    = 1'b0;
      s_araddr   = 32'd0;
      s_arsize   = 3'd0;
      s_arvalid  = 1'b0;
      s_rready   = 1'b0;
      mem_rdata  = 32'd0;
      mem_rvalid = 1'b0;
      repeat (3) step();
      ARESETn = 1'b1;

      chk("rst_arready", 32'(s_arready), 32'd1);
      chk("rst_rvalid", 32'(s_rvalid), 32'd0);
      chk("rst_rdata", s_rdata, 32'd0);
      chk("rst_rresp", 32'(s_rresp), 32'd0);
      chk("rst_mem_ren", 32'(mem_ren), 32'd0);
      chk("rst_mem_raddr", mem_raddr, 32'd0);
      chk("rst_mem_wmask", 32'(mem_wmask), 32'h4);

      // Aligned word read and byte-lane placement.
      do_read(32'h8000_0004, 3'd2, 32'hDEAD_BEEF, 1'b0, 0);
      do_read(32'h8000_0003, 3'd0, 32'h0000_00A5, 1'b0, 0);
      do_read(32'h8000_0002, 3'd1, 32'h1234_5678, 1'b0, 1);

      // Illegal requests: misaligned half and unsupported size.
      do_read(32'h8000_0001, 3'd1, 32'h1111_1111, 1'b0, 0);
      do_read(32'h8000_0001, 3'd3, 32'h2222_2222, 1'b0, 0);
      do_read(32'h8000_0002, 3'd2, 32'h3333_3333, 1'b0, 0);

      // Backpressure, then a back-to-back read straight after the R handshake.
      do_read(32'h8000_0010, 3'd2, 32'hCAFE_F00D, 1'b0, 5);
      do_read(32'h8000_0021, 3'd0, 32'hFFFF_FF5A, 1'b0, 0);

      // Timeout with a silent memory, then a late reply that must be ignored.
      do_read(32'h8000_0008, 3'd2, 32'h0BAD_0BAD, 1'b1, 2);
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h7777_7777;
      step();
      mem_rvalid = 1'b0;
      chk("late_rvalid_no_resp", 32'(s_rvalid), 32'd0);
      chk("late_rvalid_arready", 32'(s_arready), 32'd1);
      chk("late_rvalid_rdata", s_rdata, 32'd0);
      chk("late_rvalid_rresp", 32'(s_rresp), 32'd3);
      do_read(32'h8000_000C, 3'd2, 32'h5555_AAAA, 1'b0, 0);

      // Reset while the read is waiting on memory: no response may follow.
      do_read(32'h8000_0046, 3'd1, 32'h0000_BEEF, 1'b0, 0);
      s_araddr  = 32'h8000_0030;
      s_arsize  = 3'd2;
      s_arvalid = 1'b1;
      step();
      s_arvalid = 1'b0;
      step();
      step();
      ARESETn = 1'b0;
      step();
      ARESETn = 1'b1;
      chk("midrst_arready", 32'(s_arready), 32'd1);
      chk("midrst_rvalid", 32'(s_rvalid), 32'd0);
      chk("midrst_rdata", s_rdata, 32'd0);
      chk("midrst_rresp", 32'(s_rresp), 32'd0);
      chk("midrst_mem_ren", 32'(mem_ren), 32'd0);
      chk("midrst_mem_raddr", mem_raddr, 32'd0);
      chk("midrst_mem_wmask", 32'(mem_wmask), 32'h4);
      begin
         bit seen;
         seen = 1'b0;
         for (int i = 0; i < 8; i++) begin
            step();
            if (s_rvalid) seen = 1'b1;
         end
         chk("midrst_no_response", 32'(seen), 32'd0);
      end
      do_read(32'h8000_0030, 3'd2, 32'h0102_0304, 1'b0, 0);

      // Random reads against the reference model.
      for (int n = 0; n < 40; n++) begin
         a = 32'h8000_0000 | ($urandom & 32'h0000_FFFF);
         if ($urandom_range(0, 5) == 0)
            sz = 3'($urandom_range(3, 7));
         else
            sz = 3'($urandom_range(0, 2));
         do_read(a, sz, $urandom, ($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
